// File: rtl/timer_ctrl.sv
// Egg-timer control: owns the programmed MM:SS cook time and the SET/RUN/PAUSE/ALARM machine,
// and produces the count tick, enables and counter-load strobe for the downstream BCD counter.
module timer_ctrl #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_p,
  input  logic       stop_p,
  input  logic       sec_inc_p,
  input  logic       min_inc_p,
  input  logic       clear_p,
  input  logic [3:0] seconds,
  input  logic [3:0] tens_seconds,
  input  logic [3:0] minutes,
  input  logic [3:0] tens_minutes,
  output logic [3:0] seconds_prog,
  output logic [3:0] tens_seconds_prog,
  output logic [3:0] minutes_prog,
  output logic [3:0] tens_minutes_prog,
  output logic       count_enable,
  output logic       main_enable,
  output logic       ctr_load,
  output logic       alarm,
  output logic [1:0] state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(ALARM_TICKS + 1);

  localparam logic [1:0] ST_SET   = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_ALARM = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc, presc_d;
  logic [AW-1:0] alarm_cnt, alarm_cnt_d;
  logic          sec_inc, min_inc, prog_clr;
  logic          presc_last, count_zero, prog_nz;

  function automatic logic [7:0] inc_sec(input logic [3:0] tens, input logic [3:0] ones);
    if (ones != 4'd9) return {tens, ones + 4'd1};
    return (tens == 4'd5) ? 8'h00 : {tens + 4'd1, 4'd0};
  endfunction

  function automatic logic [7:0] inc_min(input logic [3:0] tens, input logic [3:0] ones);
    if (ones != 4'd9) return {tens, ones + 4'd1};
    return (tens == 4'd9) ? 8'h00 : {tens + 4'd1, 4'd0};
  endfunction

  assign presc_last = (presc == PW'(TICK_DIV - 1));
  assign count_zero = ~|{tens_minutes, minutes, tens_seconds, seconds};
  assign prog_nz    = |{tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog};

  // Buttons are tested in priority order clear > stop > start > increments in every state.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc;
    alarm_cnt_d = alarm_cnt;
    sec_inc     = 1'b0;
    min_inc     = 1'b0;
    prog_clr    = 1'b0;
    case (state_q)
      ST_SET: begin
        if (clear_p) prog_clr = 1'b1;
        else if (stop_p) state_d = ST_SET;
        else if (start_p) begin
          if (prog_nz) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end else begin
          sec_inc = sec_inc_p;
          min_inc = min_inc_p;
        end
      end
      ST_RUN: begin
        presc_d = presc_last ? '0 : presc + PW'(1);
        if (clear_p) state_d = ST_SET;
        else if (stop_p) state_d = ST_PAUSE;
        else if (count_zero) begin
          // Restart the prescaler so the alarm lasts a whole number of ticks.
          state_d     = ST_ALARM;
          presc_d     = '0;
          alarm_cnt_d = '0;
        end
      end
      ST_PAUSE: begin
        if (clear_p || stop_p) state_d = ST_SET;
        else if (start_p) state_d = ST_RUN;
      end
      default: begin
        presc_d = presc_last ? '0 : presc + PW'(1);
        if (clear_p || stop_p || start_p) begin
          state_d     = ST_SET;
          alarm_cnt_d = '0;
        end else if (presc_last) begin
          if (alarm_cnt == AW'(ALARM_TICKS - 1)) begin
            state_d     = ST_SET;
            alarm_cnt_d = '0;
          end else begin
            alarm_cnt_d = alarm_cnt + AW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SET;
      presc     <= '0;
      alarm_cnt <= '0;
    end else begin
      state_q   <= state_d;
      presc     <= presc_d;
      alarm_cnt <= alarm_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || prog_clr) begin
      seconds_prog      <= '0;
      tens_seconds_prog <= '0;
      minutes_prog      <= '0;
      tens_minutes_prog <= '0;
    end else begin
      if (sec_inc) {tens_seconds_prog, seconds_prog} <= inc_sec(tens_seconds_prog, seconds_prog);
      if (min_inc) {tens_minutes_prog, minutes_prog} <= inc_min(tens_minutes_prog, minutes_prog);
    end
  end

  assign state        = state_q;
  assign main_enable  = (state_q == ST_RUN);
  assign ctr_load     = (state_q == ST_SET);
  assign alarm        = (state_q == ST_ALARM);
  assign count_enable = (state_q == ST_RUN) && presc_last && !count_zero;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural BCD downcounter standing in for time_count.
module tb_timer_ctrl;

  localparam logic [4:0] B_SEC = 5'b00001;
  localparam logic [4:0] B_MIN = 5'b00010;
  localparam logic [4:0] B_STA = 5'b00100;
  localparam logic [4:0] B_STO = 5'b01000;
  localparam logic [4:0] B_CLR = 5'b10000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  btn = '0;
  logic [15:0] cnt;
  logic [3:0]  s_p, ts_p, m_p, tm_p;
  logic        count_enable, main_enable, ctr_load, alarm;
  logic [1:0]  state;
  logic [15:0] prog;
  int          n_vec = 0;
  int          n_err = 0;

  assign prog = {tm_p, m_p, ts_p, s_p};

  always #5 clk = ~clk;

  timer_ctrl #(.TICK_DIV(4), .ALARM_TICKS(3)) dut (
    .clk(clk), .reset(reset),
    .start_p(btn[2]), .stop_p(btn[3]), .sec_inc_p(btn[0]), .min_inc_p(btn[1]), .clear_p(btn[4]),
    .seconds(cnt[3:0]), .tens_seconds(cnt[7:4]), .minutes(cnt[11:8]), .tens_minutes(cnt[15:12]),
    .seconds_prog(s_p), .tens_seconds_prog(ts_p), .minutes_prog(m_p), .tens_minutes_prog(tm_p),
    .count_enable(count_enable), .main_enable(main_enable), .ctr_load(ctr_load),
    .alarm(alarm), .state(state)
  );

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (r[3:0] != 0) r[3:0] = r[3:0] - 1;
    else begin
      r[3:0] = 9;
      if (r[7:4] != 0) r[7:4] = r[7:4] - 1;
      else begin
        r[7:4] = 5;
        if (r[11:8] != 0) r[11:8] = r[11:8] - 1;
        else begin
          r[11:8] = 9;
          r[15:12] = (r[15:12] != 0) ? r[15:12] - 1 : 4'd9;
        end
      end
    end
    return r;
  endfunction

  // Downstream counter: ctr_load reloads the programmed time, count_enable steps it down.
  always_ff @(posedge clk) begin
    if (ctr_load) cnt <= prog;
    else if (count_enable) cnt <= bcd_dec(cnt);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [4:0] b);
    btn = b;
    @(negedge clk);
    btn = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] hist;
    int          n;
    logic        seen;

    // 1. reset
    #2 reset = 1'b0;
    #1;
    chk("rst state", state, 2'b00);
    chk("rst prog", prog, 16'h0000);
    chk("rst ctr_load", ctr_load, 1'b1);
    chk("rst count_enable", count_enable, 1'b0);
    chk("rst main_enable", main_enable, 1'b0);
    chk("rst alarm", alarm, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 2. programming, wraps, clear, start with zero program
    repeat (60) press(B_SEC);
    chk("sec wrap 59->00", prog, 16'h0000);
    press(B_SEC);
    repeat (112) press(B_MIN);
    chk("prog 12:01", prog, 16'h1201);
    press(B_CLR);
    chk("clear prog", prog, 16'h0000);
    press(B_STA);
    chk("start at 00:00", state, 2'b00);
    press(B_SEC | B_MIN);
    chk("sec+min together", prog, 16'h0101);
    press(B_CLR | B_SEC);
    chk("clear beats inc", prog, 16'h0000);

    // 3. run 00:05 to alarm
    repeat (5) press(B_SEC);
    chk("prog 00:05", prog, 16'h0005);
    press(B_STA);
    hist = '0;
    for (int k = 1; k <= 21; k++) begin
      hist[k] = count_enable;
      if (k == 1) chk("main_enable in RUN", main_enable, 1'b1);
      if (k == 21) begin
        chk("count at zero", cnt, 16'h0000);
        chk("RUN while zero", state, 2'b01);
      end
      @(negedge clk);
    end
    chk("tick pattern", hist, 32'h0011_1110);
    chk("ALARM entered", state, 2'b11);
    n = 0;
    while (alarm && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("alarm cycles", n, 12);
    chk("back to SET", state, 2'b00);
    chk("ctr_load after alarm", ctr_load, 1'b1);
    @(negedge clk);
    chk("counter reloaded", cnt, 16'h0005);

    // 3b. alarm aborted by a button
    press(B_STA);
    n = 0;
    while (!alarm && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("alarm reached", alarm, 1'b1);
    press(B_STA);
    chk("alarm abort", state, 2'b00);
    chk("prog kept", prog, 16'h0005);

    // 4. pause and resume preserve the prescaler phase
    press(B_CLR);
    press(B_MIN);
    press(B_STA);
    n = 0;
    while (!count_enable && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("first tick found", count_enable, 1'b1);
    repeat (2) @(negedge clk);
    press(B_STO);
    chk("PAUSE", state, 2'b10);
    chk("count 00:59", cnt, 16'h0059);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      seen |= count_enable | main_enable;
      @(negedge clk);
    end
    chk("quiet in PAUSE", seen, 1'b0);
    press(B_STA);
    chk("resume +1 no tick", count_enable, 1'b0);
    @(negedge clk);
    chk("resume +2 tick", count_enable, 1'b1);
    chk("count held 00:59", cnt, 16'h0059);
    @(negedge clk);
    chk("count 00:58", cnt, 16'h0058);

    // 5. simultaneous buttons
    press(B_CLR | B_STA);
    chk("RUN clear+start", state, 2'b00);
    chk("prog retained", prog, 16'h0100);
    press(B_STA);
    chk("RUN again", state, 2'b01);
    press(B_STO);
    chk("PAUSE again", state, 2'b10);
    press(B_STO | B_STA);
    chk("PAUSE stop+start", state, 2'b00);

    // 6. asynchronous reset in mid-RUN
    press(B_STA);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async state", state, 2'b00);
    chk("async main_enable", main_enable, 1'b0);
    chk("async count_enable", count_enable, 1'b0);
    chk("async ctr_load", ctr_load, 1'b1);
    chk("async prog", prog, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post reset state", state, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
